// File: rtl/pwm_multi_pkg.sv
// Shared constants and helpers for the multi-channel PWM/PDM DAC stage.
// Imported by the channel slice and the top level.
package pwm_multi_pkg;

  localparam logic MODE_PWM = 1'b0;
  localparam logic MODE_PDM = 1'b1;

  function automatic int unsigned midscale(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/pwm_ch.sv
// One DAC channel: offset conversion, double-buffered duty,
// PDM accumulator and the registered 1-bit output.
module pwm_ch
  import pwm_multi_pkg::*;
#(
  parameter int W = 10
) (
  input  logic         clk_in,
  input  logic         rstn,
  input  logic         i_en,
  input  logic         i_mode,
  input  logic         i_mode_chg,
  input  logic         i_load,
  input  logic         i_valid,
  input  logic [W-1:0] i_cnt,
  input  logic [W-1:0] i_data,
  output logic         o_out
);

  localparam logic [W-1:0] MID = W'(midscale(W));

  logic [W-1:0] r_shadow;
  logic [W-1:0] r_active;
  logic [W-1:0] r_acc;
  logic         r_out;

  logic [W-1:0] w_u;
  logic [W-1:0] w_src;
  logic [W:0]   w_sum;

  assign w_u   = {~i_data[W-1], i_data[W-2:0]};
  assign w_src = i_valid ? w_u : r_shadow;
  assign w_sum = {1'b0, r_acc} + {1'b0, r_active};

  always_ff @(posedge clk_in) begin
    if (!rstn) begin
      r_shadow <= MID;
      r_active <= MID;
      r_acc    <= '0;
      r_out    <= 1'b0;
    end else begin
      if (i_valid) r_shadow <= w_u;
      // a sample arriving in a load cycle bypasses the shadow
      if (i_mode == MODE_PDM || i_load) r_active <= w_src;
      if (!i_en || i_mode_chg || i_mode == MODE_PWM)
        r_acc <= '0;
      else
        r_acc <= w_sum[W-1:0];
      if (i_mode == MODE_PDM)
        r_out <= i_en & w_sum[W];
      else
        r_out <= i_en & (i_cnt < r_active);
    end
  end

  assign o_out = r_out;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM / sigma-delta DAC output stage with shared
// period counter, sample-request strobe and sticky overrun flag.
module pwm_multi
  import pwm_multi_pkg::*;
#(
  parameter int DATA_IN_WIDTH = 10,
  parameter int NUM_CH        = 2
) (
  input  logic                            clk_in,
  input  logic                            rstn,
  input  logic                            pwm_en,
  input  logic                            mode,
  input  logic                            data_valid,
  input  logic [NUM_CH*DATA_IN_WIDTH-1:0] data_in,
  input  logic                            clr_ovr,
  output logic [NUM_CH-1:0]               pwm_out,
  output logic                            period_start,
  output logic                            overrun
);

  localparam int W = DATA_IN_WIDTH;
  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] r_cnt;
  logic         r_pending;
  logic         r_overrun;
  logic         r_mode;

  logic w_mode_chg;
  logic w_load;
  logic w_ovr_set;

  assign w_mode_chg = (mode != r_mode);
  assign w_load     = (mode == MODE_PWM) && (r_cnt == CNT_MAX);
  assign w_ovr_set  = data_valid & r_pending & ~w_load
                    & (mode == MODE_PWM);

  always_ff @(posedge clk_in) begin
    if (!rstn) begin
      r_cnt     <= '0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
      r_mode    <= MODE_PWM;
    end else begin
      r_cnt  <= r_cnt + W'(1);
      r_mode <= mode;
      if (mode == MODE_PDM || w_mode_chg || w_load)
        r_pending <= 1'b0;
      else if (data_valid)
        r_pending <= 1'b1;
      // set has priority over clear
      if (w_ovr_set)
        r_overrun <= 1'b1;
      else if (clr_ovr)
        r_overrun <= 1'b0;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pwm_ch #(.W(W)) u_ch (
      .clk_in     (clk_in),
      .rstn       (rstn),
      .i_en       (pwm_en),
      .i_mode     (mode),
      .i_mode_chg (w_mode_chg),
      .i_load     (w_load),
      .i_valid    (data_valid),
      .i_cnt      (r_cnt),
      .i_data     (data_in[c*W +: W]),
      .o_out      (pwm_out[c])
    );
  end

  assign period_start = (r_cnt == '0) && (mode == MODE_PWM);
  assign overrun      = r_overrun;

endmodule
